johnson_seq_ctrl: RTL

//  Run/pause/step/burst sequencer for the board's Johnson counter datapath.

---
 rtl/johnson_seq_ctrl_if.sv | 60 ++++++
 rtl/johnson_seq_ctrl.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/johnson_seq_ctrl_if.sv
// Handshake/command bundle between the KEY/SW decode (master) and the
// Johnson counter sequencer (slave). Carries the command pulses, the
// run configuration and the registered drive/status back to the counter.
interface johnson_seq_ctrl_if #(
    parameter int unsigned BURST_W = 8
);

    // Command pulses and configuration from the key/switch decode
    logic               start;
    logic               stop;
    logic               step;
    logic               clear;
    logic               dir_in;
    logic [4:0]         rate_sel;
    logic [BURST_W-1:0] burst_len;

    // Counter drive and status from the sequencer
    logic               cnt_en;
    logic               cnt_clr;
    logic               cnt_dir;
    logic               busy;
    logic               done;
    logic [1:0]         state;
    logic [BURST_W-1:0] steps_done;

    modport master (
        output start,
        output stop,
        output step,
        output clear,
        output dir_in,
        output rate_sel,
        output burst_len,
        input  cnt_en,
        input  cnt_clr,
        input  cnt_dir,
        input  busy,
        input  done,
        input  state,
        input  steps_done
    );

    modport slave (
        input  start,
        input  stop,
        input  step,
        input  clear,
        input  dir_in,
        input  rate_sel,
        input  burst_len,
        output cnt_en,
        output cnt_clr,
        output cnt_dir,
        output busy,
        output done,
        output state,
        output steps_done
    );

endinterface

// File: rtl/johnson_seq_ctrl.sv
// Run/pause/step/burst sequencer for the Johnson counter datapath.
// Single clock domain: an internal prescaler produces rate ticks from clk and
// the counter is driven by registered enable/clear/direction pulses. Every
// output reflects the decision taken in the previous cycle.
module johnson_seq_ctrl #(
    parameter int unsigned DIV_W   = 32,
    parameter int unsigned BURST_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    johnson_seq_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRun   = 2'd1,
        StPause = 2'd2,
        StStep  = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [4:0]         rate_q, rate_d;
    logic [BURST_W-1:0] len_q, len_d;
    logic [BURST_W-1:0] steps_q, steps_d;
    logic               dir_q, dir_d;
    logic               en_q, en_d;
    logic               clr_q, clr_d;
    logic               done_q, done_d;
    logic               busy_q, busy_d;

    logic [DIV_W-1:0]   tick_match;
    logic [DIV_W-1:0]   tick_mask;
    logic               tick;
    logic [BURST_W-1:0] steps_inc;

    // Rate tick: low rate_q+1 bits of the prescaler equal 1<<rate_q, so the
    // first tick lands half a period after RUN entry.
    always_comb begin
        tick_match = DIV_W'(1) << rate_q;
        tick_mask  = (tick_match << 1) - DIV_W'(1);
        tick       = (state_q == StRun) && ((div_q & tick_mask) == tick_match);
        steps_inc  = steps_q + BURST_W'(1);
    end

    // Next-state and registered-output decisions; clear beats stop beats
    // start beats step, and lower-priority pulses are simply dropped.
    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        rate_d  = rate_q;
        len_d   = len_q;
        steps_d = steps_q;
        dir_d   = dir_q;
        en_d    = 1'b0;
        clr_d   = 1'b0;
        done_d  = 1'b0;

        // The prescaler free-runs while in RUN, including the cycle a stop
        // arrives, so a resume keeps the original tick phase.
        if (state_q == StRun) begin
            div_d = div_q + DIV_W'(1);
        end

        if (bus.clear) begin
            state_d = StIdle;
            clr_d   = 1'b1;
            steps_d = '0;
            div_d   = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.start) begin
                        state_d = StRun;
                        div_d   = '0;
                        rate_d  = bus.rate_sel;
                        len_d   = bus.burst_len;
                        dir_d   = bus.dir_in;
                        steps_d = '0;
                    end else if (bus.step) begin
                        state_d = StStep;
                        dir_d   = bus.dir_in;
                    end
                end
                StRun: begin
                    if (bus.stop) begin
                        // A tick coinciding with stop is swallowed.
                        state_d = StPause;
                    end else if (tick) begin
                        en_d    = 1'b1;
                        steps_d = steps_inc;
                        if ((len_q != '0) && (steps_inc == len_q)) begin
                            done_d  = 1'b1;
                            state_d = StIdle;
                        end
                    end
                end
                StPause: begin
                    if (bus.stop) begin
                        state_d = StIdle;
                    end else if (bus.start) begin
                        // Resume: prescaler, rate, length and count retained.
                        state_d = StRun;
                    end else if (bus.step) begin
                        state_d = StStep;
                        dir_d   = bus.dir_in;
                    end
                end
                StStep: begin
                    // Single advance; never raises done even if it hits len_q.
                    en_d    = 1'b1;
                    steps_d = steps_inc;
                    state_d = StPause;
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end

        busy_d = (state_d == StRun) || (state_d == StStep);
    end

    // State and output registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            div_q   <= '0;
            rate_q  <= '0;
            len_q   <= '0;
            steps_q <= '0;
            dir_q   <= 1'b0;
            en_q    <= 1'b0;
            clr_q   <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            rate_q  <= rate_d;
            len_q   <= len_d;
            steps_q <= steps_d;
            dir_q   <= dir_d;
            en_q    <= en_d;
            clr_q   <= clr_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.cnt_en     = en_q;
    assign bus.cnt_clr    = clr_q;
    assign bus.cnt_dir    = dir_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.state      = state_q;
    assign bus.steps_done = steps_q;

endmodule
